// File: rtl/timer_pkg.sv
// Shared types and BCD helpers for the multi-phase countdown timer.
package timer_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned BIN_W = 7;

  typedef enum logic [1:0] {IDLE, RUN, AMBER} state_e;
  typedef logic [BCD_W-1:0] bcd_t;

  // Clamp a raw nibble into a legal decimal digit.
  function automatic bcd_t bcd_sat(input bcd_t d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  // Two legal BCD digits to binary 0..99; callers saturate digits first.
  function automatic logic [BIN_W-1:0] bcd_to_bin(input bcd_t hi, input bcd_t lo);
    return BIN_W'(hi) * BIN_W'(10) + BIN_W'(lo);
  endfunction

  // Binary 0..99 to {tens, units}.
  function automatic logic [2*BCD_W-1:0] bin_to_bcd(input logic [BIN_W-1:0] b);
    logic [BIN_W-1:0] tens;
    tens = b / BIN_W'(10);
    return {BCD_W'(tens), BCD_W'(b - tens * BIN_W'(10))};
  endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD load/decrement counter; is_one_o flags a display of 01.
module bcd_down_counter
  import timer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic       dec_i,
  input  logic [3:0] load_hi_i,
  input  logic [3:0] load_lo_i,
  output logic [3:0] hi_o,
  output logic [3:0] lo_o,
  output logic       is_one_o
);

  bcd_t hi_q, hi_d;
  bcd_t lo_q, lo_d;
  logic is_one_q;

  // Load wins over decrement; decrement stops at 00.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (load_i) begin
      hi_d = load_hi_i;
      lo_d = load_lo_i;
    end else if (dec_i && ((hi_q != 4'd0) || (lo_q != 4'd0))) begin
      if (lo_q != 4'd0) begin
        lo_d = lo_q - 4'd1;
      end else begin
        lo_d = 4'd9;
        hi_d = hi_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi_q     <= 4'd0;
      lo_q     <= 4'd0;
      is_one_q <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_one_q <= (hi_d == 4'd0) && (lo_d == 4'd1);
    end
  end

  assign hi_o     = hi_q;
  assign lo_o     = lo_q;
  assign is_one_o = is_one_q;

endmodule

// File: rtl/multi_phase_timer.sv
// Cycles NUM_PHASES programmable BCD countdown phases on a tick strobe.
// Define TIMER_AMBER_EN to insert an AMBER_TICKS amber interval between phases.
module multi_phase_timer
  import timer_pkg::*;
#(
  parameter int unsigned NUM_PHASES  = 2,
  parameter int unsigned SCALE       = 5,
  parameter int unsigned MAX_COUNT   = 90,
  parameter int unsigned AMBER_TICKS = 3,
  localparam int unsigned PH_W = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    enable,
  input  logic [4*NUM_PHASES-1:0] count_hi,
  input  logic [4*NUM_PHASES-1:0] count_lo,
  output logic [3:0]              out_hi,
  output logic [3:0]              out_lo,
  output logic [PH_W-1:0]         phase,
  output logic                    phase_start,
  output logic                    amber
);

  localparam int unsigned DUR_W = 16;

  state_e            state_q;
  logic [PH_W-1:0]   phase_q;
  logic              phase_start_q;
  logic              evt_c;
  logic              is_one_c;
  logic [PH_W-1:0]   next_phase_c;
  logic [PH_W-1:0]   load_phase_c;
  bcd_t              sel_hi_c, sel_lo_c;
  logic [DUR_W-1:0]  dur_bin_c;
  logic [7:0]        dur_bcd_c;
  logic              amber_load_c;
  logic              cnt_load_c, cnt_dec_c;
  logic [7:0]        cnt_load_val_c;

  assign evt_c        = tick & enable;
  assign next_phase_c = (phase_q == PH_W'(NUM_PHASES - 1)) ? '0 : phase_q + PH_W'(1);
  assign load_phase_c = (state_q == IDLE) ? phase_q : next_phase_c;

  // Duration of the phase about to load, from the live configuration.
  always_comb begin
    sel_hi_c = '0;
    sel_lo_c = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      if (load_phase_c == PH_W'(p)) begin
        sel_hi_c = count_hi[4*p +: 4];
        sel_lo_c = count_lo[4*p +: 4];
      end
    end
    dur_bin_c = DUR_W'(bcd_to_bin(bcd_sat(sel_hi_c), bcd_sat(sel_lo_c))) * DUR_W'(SCALE);
    if (dur_bin_c > DUR_W'(MAX_COUNT)) dur_bin_c = DUR_W'(MAX_COUNT);
    if (dur_bin_c == '0) dur_bin_c = DUR_W'(1);
    dur_bcd_c = bin_to_bcd(BIN_W'(dur_bin_c));
  end

`ifdef TIMER_AMBER_EN
  logic amber_q;
  assign amber_load_c = evt_c && (state_q == RUN) && is_one_c;
  assign amber        = amber_q;
`else
  assign amber_load_c = 1'b0;
  assign amber        = 1'b0;
`endif

  assign cnt_load_c     = evt_c && ((state_q == IDLE) || is_one_c);
  assign cnt_dec_c      = evt_c && (state_q != IDLE) && !is_one_c;
  assign cnt_load_val_c = amber_load_c ? {4'd0, 4'(AMBER_TICKS)} : dur_bcd_c;

  bcd_down_counter u_cnt (
    .clk_i     (clock),
    .rst_i     (reset),
    .load_i    (cnt_load_c),
    .dec_i     (cnt_dec_c),
    .load_hi_i (cnt_load_val_c[7:4]),
    .load_lo_i (cnt_load_val_c[3:0]),
    .hi_o      (out_hi),
    .lo_o      (out_lo),
    .is_one_o  (is_one_c)
  );

  // Phase sequencing; phase_start self-clears even while held.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      phase_start_q <= 1'b0;
`ifdef TIMER_AMBER_EN
      amber_q       <= 1'b0;
`endif
    end else begin
      phase_start_q <= 1'b0;
      if (evt_c) begin
        case (state_q)
          IDLE: begin
            state_q       <= RUN;
            phase_start_q <= 1'b1;
          end
          RUN: begin
            if (is_one_c) begin
`ifdef TIMER_AMBER_EN
              state_q       <= AMBER;
              amber_q       <= 1'b1;
`else
              phase_q       <= next_phase_c;
              phase_start_q <= 1'b1;
`endif
            end
          end
          AMBER: begin
            if (is_one_c) begin
              state_q       <= RUN;
              phase_q       <= next_phase_c;
              phase_start_q <= 1'b1;
`ifdef TIMER_AMBER_EN
              amber_q       <= 1'b0;
`endif
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign phase       = phase_q;
  assign phase_start = phase_start_q;

endmodule
